motor_drive_sequencer: RTL



---
 rtl/motor_drive_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/motor_drive_sequencer.sv
// ---------------------------------------------------------------------------
// motor_drive_sequencer
//
// Places a safety sequencer between the motor command logic and the drive
// pads for two motors. Each motor has a forward and a reverse drive line.
// The sequencer guarantees that:
//   - the two lines of one motor are never high together,
//   - every drive is held for at least MIN_ON_CYC cycles unless a safety
//     condition forces it off,
//   - both lines stay low for a dead-time after any drive ends, and
//   - a drive never switches directly from forward to reverse.
//
// The two channels are independent. They share only the clock, the reset,
// the enable and (optionally) the watchdog.
//
// Optional build macro: MOTOR_WDOG_EN
//   If defined, a heartbeat watchdog is built. If hb does not change for
//   WDOG_CYC cycles, wdog_trip latches and both channels are forced off.
//   If not defined, hb is ignored and wdog_trip is tied to 0.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         drive enable (robot mode not OFF)
//   req_l      left request  [0]=forward [1]=reverse (2'b11 is illegal)
//   req_r      right request [0]=forward [1]=reverse (2'b11 is illegal)
//   hb         heartbeat from the mode logic (used only with MOTOR_WDOG_EN)
//   min11      left forward drive       (registered)
//   min21      left reverse drive       (registered)
//   min12      right forward drive      (registered)
//   min22      right reverse drive      (registered)
//   busy_l     left channel in dead-time   (registered)
//   busy_r     right channel in dead-time  (registered)
//   fault      sticky: an illegal request was sampled
//   wdog_trip  sticky: heartbeat watchdog expired
//
// Handshake: there is none. Requests are level signals sampled on every
// clk edge. Each output is a registered level that changes only on a clk
// edge.
// ---------------------------------------------------------------------------
module motor_drive_sequencer #(
  parameter int DEAD_CYC   = 1000,
  parameter int MIN_ON_CYC = 500,
  parameter int CNT_W      = 16,
  parameter int WDOG_CYC   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req_l,
  input  logic [1:0] req_r,
  input  logic       hb,
  output logic       min11,
  output logic       min21,
  output logic       min12,
  output logic       min22,
  output logic       busy_l,
  output logic       busy_r,
  output logic       fault,
  output logic       wdog_trip
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam logic [1:0] REQ_FWD     = 2'b01;
  localparam logic [1:0] REQ_REV     = 2'b10;
  localparam logic [1:0] REQ_ILLEGAL = 2'b11;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);

  // Index 0 is the left channel. Index 1 is the right channel.
  state_t           state_q [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [1:0]       req_ch  [2];
  logic [1:0]       fwd_q;
  logic [1:0]       rev_q;
  logic [1:0]       busy_q;
  logic             fault_q;
  logic             trip;

  assign req_ch[0] = req_l;
  assign req_ch[1] = req_r;

  // -------------------------------------------------------------------------
  // Heartbeat watchdog
  // -------------------------------------------------------------------------
`ifdef MOTOR_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);

  logic             hb_q;
  logic [CNT_W-1:0] wdog_cnt_q;
  logic             trip_q;

  // wdog_cnt_q counts consecutive edges at which hb did not change.
  // The trip happens on the WDOG_CYC-th such edge. After that the
  // counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_q       <= 1'b0;
      wdog_cnt_q <= '0;
      trip_q     <= 1'b0;
    end else begin
      hb_q <= hb;
      if (hb != hb_q) begin
        wdog_cnt_q <= '0;
      end else if (wdog_cnt_q == WDOG_LAST) begin
        trip_q <= 1'b1;
      end else begin
        wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end
    end
  end

  assign trip = trip_q;
`else
  logic unused_hb;
  assign unused_hb = hb;
  assign trip      = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Per-channel transition decisions
  // -------------------------------------------------------------------------
  // leave:  a drive state must end on this edge.
  //         A forced exit (enable low, illegal request or watchdog trip)
  //         ignores the hold counter. A normal exit requires the hold to
  //         have expired and the request to differ from the current
  //         direction.
  // go_fwd / go_rev:  STOP may start a drive on this edge.
  logic [1:0] leave;
  logic [1:0] go_fwd;
  logic [1:0] go_rev;
  logic [1:0] force_off;

  always_comb begin
    leave     = '0;
    go_fwd    = '0;
    go_rev    = '0;
    force_off = '0;
    for (int ch = 0; ch < 2; ch++) begin
      force_off[ch] = !en || (req_ch[ch] == REQ_ILLEGAL) || trip;
      case (state_q[ch])
        ST_STOP: begin
          go_fwd[ch] = en && !trip && (req_ch[ch] == REQ_FWD);
          go_rev[ch] = en && !trip && (req_ch[ch] == REQ_REV);
        end
        ST_FWD: begin
          leave[ch] = force_off[ch] ||
                      ((cnt_q[ch] == '0) && (req_ch[ch] != REQ_FWD));
        end
        ST_REV: begin
          leave[ch] = force_off[ch] ||
                      ((cnt_q[ch] == '0) && (req_ch[ch] != REQ_REV));
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Channel FSMs
  // -------------------------------------------------------------------------
  // Each output register is loaded together with the state, so the pads
  // follow the state on the same edge. A drive line goes high one cycle
  // after its request is sampled.
  //
  // A drive always passes through DEAD and then STOP. So after a reversal
  // request the pads are low for DEAD_CYC + 1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= ST_STOP;
        cnt_q[ch]   <= '0;
      end
      fwd_q   <= '0;
      rev_q   <= '0;
      busy_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if ((req_l == REQ_ILLEGAL) || (req_r == REQ_ILLEGAL)) begin
        fault_q <= 1'b1;
      end
      for (int ch = 0; ch < 2; ch++) begin
        case (state_q[ch])
          ST_STOP: begin
            if (go_fwd[ch]) begin
              state_q[ch] <= ST_FWD;
              cnt_q[ch]   <= HOLD_LOAD;
              fwd_q[ch]   <= 1'b1;
            end else if (go_rev[ch]) begin
              state_q[ch] <= ST_REV;
              cnt_q[ch]   <= HOLD_LOAD;
              rev_q[ch]   <= 1'b1;
            end
          end
          ST_FWD, ST_REV: begin
            if (leave[ch]) begin
              state_q[ch] <= ST_DEAD;
              cnt_q[ch]   <= DEAD_LOAD;
              fwd_q[ch]   <= 1'b0;
              rev_q[ch]   <= 1'b0;
              busy_q[ch]  <= 1'b1;
            end else if (cnt_q[ch] != '0) begin
              cnt_q[ch] <= cnt_q[ch] - 1'b1;
            end
          end
          ST_DEAD: begin
            // Requests and enable are ignored until the dead-time ends.
            if (cnt_q[ch] == '0) begin
              state_q[ch] <= ST_STOP;
              busy_q[ch]  <= 1'b0;
            end else begin
              cnt_q[ch] <= cnt_q[ch] - 1'b1;
            end
          end
          default: begin
            state_q[ch] <= ST_STOP;
            cnt_q[ch]   <= '0;
            fwd_q[ch]   <= 1'b0;
            rev_q[ch]   <= 1'b0;
            busy_q[ch]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign min11     = fwd_q[0];
  assign min21     = rev_q[0];
  assign min12     = fwd_q[1];
  assign min22     = rev_q[1];
  assign busy_l    = busy_q[0];
  assign busy_r    = busy_q[1];
  assign fault     = fault_q;
  assign wdog_trip = trip;

endmodule
